// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF/ID pipeline register.
// Opcode map, the canonical NOP and the decoded-field layout of an RV32 instruction.
package if_id_pkg;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011
    } opcode_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instr_fields_t;

endpackage

// File: rtl/rv_instr_decode.sv
// Combinational field extraction for one RV32 instruction word.
// Immediate generation is present only when IF_ID_IMM_DECODE_EN is defined.
module rv_instr_decode
    import if_id_pkg::*;
(
    input  logic [31:0]   instr,
    output instr_fields_t fields
`ifdef IF_ID_IMM_DECODE_EN
    ,
    output logic [31:0]   imm
`endif
);

    assign fields.opcode = instr[6:0];
    assign fields.rd     = instr[11:7];
    assign fields.funct3 = instr[14:12];
    assign fields.rs1    = instr[19:15];
    assign fields.rs2    = instr[24:20];
    assign fields.funct7 = instr[31:25];

`ifdef IF_ID_IMM_DECODE_EN
    // 32-bit sign-extended immediate; R-type and unknown opcodes yield zero
    always_comb begin
        imm = '0;
        case (instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR:
                imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {instr[31:12], 12'b0};
            OP_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end
`endif

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: DEPTH-entry FIFO of {instr, pc} with head-entry decode.
// Define IF_ID_IMM_DECODE_EN to add the out_imm port and immediate decode.
module if_id_pipe_reg
    import if_id_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [XLEN-1:0]          in_pc,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [XLEN-1:0]          out_pc,
    output logic [6:0]               opcode,
    output logic [4:0]               rd,
    output logic [2:0]               funct3,
    output logic [4:0]               rs1,
    output logic [4:0]               rs2,
    output logic [6:0]               funct7,
    output logic [$clog2(DEPTH):0]   count
`ifdef IF_ID_IMM_DECODE_EN
    ,
    output logic [XLEN-1:0]          out_imm
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            pop;
    instr_fields_t   fields;

    // Ready depends only on the registered count, so no out_ready -> in_ready path exists.
    assign in_ready  = (count < FULL_COUNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= '{instr: in_instr, pc: in_pc};
        end
    end

    always_comb begin
        out_instr = NOP_INSTR;
        out_pc    = '0;
        if (out_valid) begin
            out_instr = mem[rd_ptr].instr;
            out_pc    = mem[rd_ptr].pc;
        end
    end

`ifdef IF_ID_IMM_DECODE_EN
    logic [31:0] imm32;

    rv_instr_decode u_decode (
        .instr  (out_instr),
        .fields (fields),
        .imm    (imm32)
    );

    assign out_imm = XLEN'($signed(imm32));
`else
    rv_instr_decode u_decode (
        .instr  (out_instr),
        .fields (fields)
    );
`endif

    assign opcode = fields.opcode;
    assign rd     = fields.rd;
    assign funct3 = fields.funct3;
    assign rs1    = fields.rs1;
    assign rs2    = fields.rs2;
    assign funct7 = fields.funct7;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Scoreboard bench for if_id_pipe_reg: directed corner cases followed by random traffic.
// The reference is a plain queue of accepted {instr, pc} entries.
module tb_if_id_pipe_reg;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_instr = '0;
    logic [XLEN-1:0] in_pc = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      funct7;
    logic [CW-1:0]   count;
`ifdef IF_ID_IMM_DECODE_EN
    logic [XLEN-1:0] out_imm;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    ent_t mdl_q[$];

    if_id_pipe_reg #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .opcode    (opcode),
        .rd        (rd),
        .funct3    (funct3),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct7    (funct7),
        .count     (count)
`ifdef IF_ID_IMM_DECODE_EN
        ,
        .out_imm   (out_imm)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef IF_ID_IMM_DECODE_EN
    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        logic [31:0] r;
        r = 32'd0;
        case (w[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: r = {{20{w[31]}}, w[31:20]};
            7'b0100011: r = {{20{w[31]}}, w[31:25], w[11:7]};
            7'b1100011: r = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            7'b0110111, 7'b0010111: r = {w[31:12], 12'd0};
            7'b1101111: r = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: r = 32'd0;
        endcase
        return r;
    endfunction
`endif

    // Monitor: compare DUT head against the scoreboard, then advance the model for the next edge.
    always @(negedge clk) begin
        logic [31:0] e_instr;
        logic [XLEN-1:0] e_pc;
        bit do_push, do_pop;
        if (!rst_n) begin
            mdl_q.delete();
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_in_ready",  64'(in_ready),  64'd1);
            chk("rst_count",     64'(count),     64'd0);
            chk("rst_out_instr", 64'(out_instr), 64'(NOP));
        end else begin
            if (mdl_q.size() != 0) begin
                e_instr = mdl_q[0].instr;
                e_pc    = mdl_q[0].pc;
            end else begin
                e_instr = NOP;
                e_pc    = '0;
            end
            chk("out_valid", 64'(out_valid), 64'(mdl_q.size() != 0));
            chk("in_ready",  64'(in_ready),  64'(mdl_q.size() < DEPTH));
            chk("count",     64'(count),     64'(mdl_q.size()));
            chk("out_instr", 64'(out_instr), 64'(e_instr));
            chk("out_pc",    64'(out_pc),    64'(e_pc));
            chk("fields", 64'({funct7, rs2, rs1, funct3, rd, opcode}),
                64'({e_instr[31:25], e_instr[24:20], e_instr[19:15],
                     e_instr[14:12], e_instr[11:7], e_instr[6:0]}));
`ifdef IF_ID_IMM_DECODE_EN
            chk("out_imm", 64'(out_imm), 64'(XLEN'($signed(ref_imm(e_instr)))));
`endif
            if (flush) begin
                mdl_q.delete();
            end else begin
                do_pop  = (mdl_q.size() != 0) && out_ready;
                do_push = in_valid && (mdl_q.size() < DEPTH);
                if (do_pop)  void'(mdl_q.pop_front());
                if (do_push) mdl_q.push_back('{instr: in_instr, pc: in_pc});
            end
        end
    end

    task automatic step(input bit iv, input logic [31:0] ins, input logic [XLEN-1:0] pc,
                        input bit ordy, input bit fl);
        in_valid  = iv;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] r;
        logic [6:0]  ops [9];
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step(0, 32'h0, 0, 0, 0);

        // Single push into empty FIFO shows up one cycle later, decoded
        step(1, 32'h01CE0333, 32'h100, 0, 0);
        chk("p1_valid",  64'(out_valid), 64'd1);
        chk("p1_opcode", 64'(opcode), 64'h33);
        chk("p1_rd",     64'(rd),     64'd6);
        chk("p1_funct3", 64'(funct3), 64'd0);
        chk("p1_rs1",    64'(rs1),    64'd28);
        chk("p1_rs2",    64'(rs2),    64'd28);
        chk("p1_funct7", 64'(funct7), 64'd0);
        chk("p1_pc",     64'(out_pc), 64'h100);

        // Fill and overflow while downstream stalls
        step(1, 32'h00108093, 32'h104, 0, 0);
        chk("full_ready", 64'(in_ready), 64'd0);
        chk("full_count", 64'(count), 64'd2);
        step(1, 32'h00208113, 32'h108, 0, 0);
        chk("ovf_count", 64'(count), 64'd2);
        chk("ovf_head",  64'(out_pc), 64'h100);

        // Full with push and pop offered: pop only
        step(1, 32'h00308193, 32'h10C, 1, 0);
        chk("fpop_count", 64'(count), 64'd1);
        chk("fpop_head",  64'(out_pc), 64'h104);
        step(1, 32'h00408213, 32'h110, 1, 0);
        chk("pp_count", 64'(count), 64'd1);
        chk("pp_head",  64'(out_pc), 64'h110);

        // Flush with a same-cycle push drops everything
        step(1, 32'h00508293, 32'h114, 0, 0);
        chk("pre_flush_count", 64'(count), 64'd2);
        step(1, 32'h00608313, 32'h118, 0, 1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_instr", 64'(out_instr), 64'(NOP));

        // Reset between edges with stored data
        step(1, 32'h00708393, 32'h11C, 0, 0);
        step(1, 32'h00808413, 32'h120, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_count", 64'(count), 64'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step(1, 32'h00908493, 32'h200, 0, 0);
        step(0, 32'h0, 0, 1, 0);
        chk("post_rst_count", 64'(count), 64'd0);

`ifdef IF_ID_IMM_DECODE_EN
        step(1, 32'hFFF00093, 32'h300, 0, 0);
        chk("imm_all_ones", 64'(out_imm), 64'({XLEN{1'b1}}));
        step(0, 32'h0, 0, 1, 0);
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom;
            if ($urandom_range(0, 1) == 0) r[6:0] = ops[$urandom_range(0, 8)];
            step($urandom_range(0, 9) < 7, r, XLEN'($urandom),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0);
        end
        step(0, 32'h0, 0, 1, 0);
        step(0, 32'h0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
